// File: rtl/fpu_add_arbiter.sv
// Two-requester arbiter in front of one shared combinational FP add/sub/compare unit.
// Define FPU_ARB_RR_EN for round-robin grant; otherwise port 0 has fixed priority.
module fpu_add_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             io_req0_valid,
    output logic             io_req0_ready,
    input  logic [31:0]      io_req0_bits_a,
    input  logic [31:0]      io_req0_bits_b,
    input  logic             io_req0_bits_sub,
    input  logic             io_req0_bits_comp,
    input  logic [TAG_W-1:0] io_req0_bits_tag,

    input  logic             io_req1_valid,
    output logic             io_req1_ready,
    input  logic [31:0]      io_req1_bits_a,
    input  logic [31:0]      io_req1_bits_b,
    input  logic             io_req1_bits_sub,
    input  logic             io_req1_bits_comp,
    input  logic [TAG_W-1:0] io_req1_bits_tag,

    output logic [31:0]      io_fpu_a,
    output logic [31:0]      io_fpu_b,
    output logic             io_fpu_sub,
    output logic             io_fpu_comp,
    input  logic [31:0]      io_fpu_y,

    output logic             io_resp0_valid,
    input  logic             io_resp0_ready,
    output logic [31:0]      io_resp0_bits_y,
    output logic [TAG_W-1:0] io_resp0_bits_tag,

    output logic             io_resp1_valid,
    input  logic             io_resp1_ready,
    output logic [31:0]      io_resp1_bits_y,
    output logic [TAG_W-1:0] io_resp1_bits_tag
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_e;

    state_e                     state_q, state_d;
    logic                       op_src_q, op_src_d;
    logic [31:0]                op_a_q, op_a_d;
    logic [31:0]                op_b_q, op_b_d;
    logic                       op_sub_q, op_sub_d;
    logic                       op_comp_q, op_comp_d;
    logic [TAG_W-1:0]           op_tag_q, op_tag_d;

    logic [1:0]                 slot_valid_q, slot_valid_d;
    logic [1:0][31:0]           slot_y_q, slot_y_d;
    logic [1:0][TAG_W-1:0]      slot_tag_q, slot_tag_d;

`ifdef FPU_ARB_RR_EN
    logic                       rr_ptr_q, rr_ptr_d;  // last accepted port
`endif

    logic [1:0] req_valid;
    logic [1:0] resp_ready;
    logic       op_valid;
    logic       complete;
    logic       can_accept;
    logic       grant;
    logic       accept;

    assign req_valid  = {io_req1_valid, io_req0_valid};
    assign resp_ready = {io_resp1_ready, io_resp0_ready};
    assign op_valid   = (state_q != S_IDLE);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        op_src_d     = op_src_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sub_d     = op_sub_q;
        op_comp_d    = op_comp_q;
        op_tag_d     = op_tag_q;
        slot_valid_d = slot_valid_q;
        slot_y_d     = slot_y_q;
        slot_tag_d   = slot_tag_q;

        // The held operation retires once its result slot can take the unit's output.
        complete   = op_valid && (!slot_valid_q[op_src_q] || resp_ready[op_src_q]);
        can_accept = !reset && (!op_valid || complete);

`ifdef FPU_ARB_RR_EN
        grant    = (req_valid == 2'b11) ? ~rr_ptr_q : req_valid[1];
        rr_ptr_d = rr_ptr_q;
`else
        grant    = ~req_valid[0];
`endif
        accept = can_accept && req_valid[grant];

        if (accept) begin
            op_src_d  = grant;
            op_a_d    = grant ? io_req1_bits_a    : io_req0_bits_a;
            op_b_d    = grant ? io_req1_bits_b    : io_req0_bits_b;
            op_sub_d  = grant ? io_req1_bits_sub  : io_req0_bits_sub;
            op_comp_d = grant ? io_req1_bits_comp : io_req0_bits_comp;
            op_tag_d  = grant ? io_req1_bits_tag  : io_req0_bits_tag;
`ifdef FPU_ARB_RR_EN
            rr_ptr_d  = grant;
`endif
        end

        // A write takes precedence over a dequeue, so a same-edge pair leaves the slot full.
        for (int n = 0; n < 2; n++) begin
            if (complete && (int'(op_src_q) == n)) begin
                slot_valid_d[n] = 1'b1;
                slot_y_d[n]     = io_fpu_y;
                slot_tag_d[n]   = op_tag_q;
            end else if (slot_valid_q[n] && resp_ready[n]) begin
                slot_valid_d[n] = 1'b0;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_EXEC;
            end
            S_EXEC, S_WAIT: begin
                if (accept)        state_d = S_EXEC;
                else if (complete) state_d = S_IDLE;
                else               state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments only; result slots are reset too, since
    // their valid bits and visible data must read as zero straight out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_src_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sub_q     <= 1'b0;
            op_comp_q    <= 1'b0;
            op_tag_q     <= '0;
            slot_valid_q <= '0;
            slot_y_q     <= '0;
            slot_tag_q   <= '0;
`ifdef FPU_ARB_RR_EN
            rr_ptr_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            op_src_q     <= op_src_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sub_q     <= op_sub_d;
            op_comp_q    <= op_comp_d;
            op_tag_q     <= op_tag_d;
            slot_valid_q <= slot_valid_d;
            slot_y_q     <= slot_y_d;
            slot_tag_q   <= slot_tag_d;
`ifdef FPU_ARB_RR_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign io_req0_ready = accept && !grant;
    assign io_req1_ready = accept &&  grant;

    assign io_fpu_a    = op_valid ? op_a_q    : 32'd0;
    assign io_fpu_b    = op_valid ? op_b_q    : 32'd0;
    assign io_fpu_sub  = op_valid && op_sub_q;
    assign io_fpu_comp = op_valid && op_comp_q;

    assign io_resp0_valid    = slot_valid_q[0];
    assign io_resp0_bits_y   = slot_y_q[0];
    assign io_resp0_bits_tag = slot_tag_q[0];
    assign io_resp1_valid    = slot_valid_q[1];
    assign io_resp1_bits_y   = slot_y_q[1];
    assign io_resp1_bits_tag = slot_tag_q[1];

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: directed vectors, expected results queued per response
// port and compared by a negedge monitor; a small table stands in for the shared FPU.
module tb_fpu_add_arbiter;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             io_req0_valid, io_req0_ready, io_req0_bits_sub, io_req0_bits_comp;
    logic [31:0]      io_req0_bits_a, io_req0_bits_b;
    logic [TAG_W-1:0] io_req0_bits_tag;
    logic             io_req1_valid, io_req1_ready, io_req1_bits_sub, io_req1_bits_comp;
    logic [31:0]      io_req1_bits_a, io_req1_bits_b;
    logic [TAG_W-1:0] io_req1_bits_tag;
    logic [31:0]      io_fpu_a, io_fpu_b, io_fpu_y;
    logic             io_fpu_sub, io_fpu_comp;
    logic             io_resp0_valid, io_resp0_ready, io_resp1_valid, io_resp1_ready;
    logic [31:0]      io_resp0_bits_y, io_resp1_bits_y;
    logic [TAG_W-1:0] io_resp0_bits_tag, io_resp1_bits_tag;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t q0[$];
    exp_t q1[$];

    fpu_add_arbiter #(.TAG_W(TAG_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_req0_valid     (io_req0_valid),
        .io_req0_ready     (io_req0_ready),
        .io_req0_bits_a    (io_req0_bits_a),
        .io_req0_bits_b    (io_req0_bits_b),
        .io_req0_bits_sub  (io_req0_bits_sub),
        .io_req0_bits_comp (io_req0_bits_comp),
        .io_req0_bits_tag  (io_req0_bits_tag),
        .io_req1_valid     (io_req1_valid),
        .io_req1_ready     (io_req1_ready),
        .io_req1_bits_a    (io_req1_bits_a),
        .io_req1_bits_b    (io_req1_bits_b),
        .io_req1_bits_sub  (io_req1_bits_sub),
        .io_req1_bits_comp (io_req1_bits_comp),
        .io_req1_bits_tag  (io_req1_bits_tag),
        .io_fpu_a          (io_fpu_a),
        .io_fpu_b          (io_fpu_b),
        .io_fpu_sub        (io_fpu_sub),
        .io_fpu_comp       (io_fpu_comp),
        .io_fpu_y          (io_fpu_y),
        .io_resp0_valid    (io_resp0_valid),
        .io_resp0_ready    (io_resp0_ready),
        .io_resp0_bits_y   (io_resp0_bits_y),
        .io_resp0_bits_tag (io_resp0_bits_tag),
        .io_resp1_valid    (io_resp1_valid),
        .io_resp1_ready    (io_resp1_ready),
        .io_resp1_bits_y   (io_resp1_bits_y),
        .io_resp1_bits_tag (io_resp1_bits_tag)
    );

    always #5 clock = ~clock;

    // Stand-in for the shared unit: exact results for the operand pairs used here.
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub, input logic comp);
        if (comp) return (a < b) ? 32'd1 : 32'd0;
        if (!sub && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (!sub && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (!sub && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        if ( sub && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if ( sub && a == 32'h40800000 && b == 32'h3F800000) return 32'h40400000;
        if ( sub && a == 32'h40000000 && b == 32'h3F800000) return 32'h3F800000;
        return 32'hDEADBEEF;
    endfunction

    always_comb io_fpu_y = fpu_model(io_fpu_a, io_fpu_b, io_fpu_sub, io_fpu_comp);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] y);
        n_vec++;
        n_miss++;
        $display("FAIL %s: response y=%h with nothing expected (t=%0t)", name, y, $time);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (io_resp0_valid && io_resp0_ready) begin
                if (q0.size() == 0) unexpected("resp0_spurious", io_resp0_bits_y);
                else begin
                    e = q0.pop_front();
                    check("resp0_y", io_resp0_bits_y, e.y);
                    check("resp0_tag", 32'(io_resp0_bits_tag), 32'(e.tag));
                end
            end
            if (io_resp1_valid && io_resp1_ready) begin
                if (q1.size() == 0) unexpected("resp1_spurious", io_resp1_bits_y);
                else begin
                    e = q1.pop_front();
                    check("resp1_y", io_resp1_bits_y, e.y);
                    check("resp1_tag", 32'(io_resp1_bits_tag), 32'(e.tag));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic comp, input logic [TAG_W-1:0] tag);
        if (port == 0) begin
            io_req0_valid = v; io_req0_bits_a = a; io_req0_bits_b = b;
            io_req0_bits_sub = sub; io_req0_bits_comp = comp; io_req0_bits_tag = tag;
        end else begin
            io_req1_valid = v; io_req1_bits_a = a; io_req1_bits_b = b;
            io_req1_bits_sub = sub; io_req1_bits_comp = comp; io_req1_bits_tag = tag;
        end
    endtask

    // Present one request, wait (bounded) for its ready, queue its expected response.
    task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic comp, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp_y, input bit push);
        bit got = 0;
        int waited = 0;
        set_req(port, 1'b1, a, b, sub, comp, tag);
        while (!got && waited < 20) begin
            @(negedge clock);
            if ((port == 0) ? io_req0_ready : io_req1_ready) got = 1;
            else begin
                tick();
                waited++;
            end
        end
        check("accept_in_time", 32'(got), 32'd1);
        if (got && push) begin
            if (port == 0) q0.push_back('{y: exp_y, tag: tag});
            else           q1.push_back('{y: exp_y, tag: tag});
        end
        tick();
        set_req(port, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
    endtask

    logic [31:0] p0_a[3] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    logic [31:0] p0_b[3] = '{32'h40000000, 32'h3F800000, 32'h40000000};
    logic [31:0] p0_y[3] = '{32'h40400000, 32'h40000000, 32'h40800000};
    logic [31:0] p1_a[3] = '{32'h40400000, 32'h40800000, 32'h40000000};
    logic [31:0] p1_b[3] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] p1_y[3] = '{32'h40000000, 32'h40400000, 32'h3F800000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0 = 0;
        int p1 = 0;
        int t  = 0;
        logic [1:0] exp_g;

        reset = 1'b1;
        io_resp0_ready = 1'b1;
        io_resp1_ready = 1'b1;
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        repeat (2) tick();

        // Outputs sit at reset values even with a request pending.
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4'd3);
        @(negedge clock);
        check("rst_req0_ready", 32'(io_req0_ready), 32'd0);
        check("rst_req1_ready", 32'(io_req1_ready), 32'd0);
        check("rst_resp0_valid", 32'(io_resp0_valid), 32'd0);
        check("rst_resp1_valid", 32'(io_resp1_valid), 32'd0);
        check("rst_resp0_y", io_resp0_bits_y, 32'd0);
        check("rst_resp1_tag", 32'(io_resp1_bits_tag), 32'd0);
        check("rst_fpu_a", io_fpu_a, 32'd0);
        check("rst_fpu_b", io_fpu_b, 32'd0);
        check("rst_fpu_ctl", {30'd0, io_fpu_sub, io_fpu_comp}, 32'd0);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        tick();
        reset = 1'b0;
        tick();

        // Both ports contend for six cycles: alternate under round-robin, port 0 otherwise.
        set_req(0, 1'b1, p0_a[0], p0_b[0], 1'b0, 1'b0, 4'(p0));
        set_req(1, 1'b1, p1_a[0], p1_b[0], 1'b1, 1'b0, 4'(8 + p1));
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
`ifdef FPU_ARB_RR_EN
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            check($sformatf("grant_%0d", c), {30'd0, io_req1_ready, io_req0_ready}, {30'd0, exp_g});
            if (io_req0_ready) q0.push_back('{y: p0_y[p0 % 3], tag: 4'(p0)});
            if (io_req1_ready) q1.push_back('{y: p1_y[p1 % 3], tag: 4'(8 + p1)});
            tick();
            if (exp_g[0]) p0++;
            if (exp_g[1]) p1++;
            set_req(0, 1'b1, p0_a[p0 % 3], p0_b[p0 % 3], 1'b0, 1'b0, 4'(p0));
            set_req(1, 1'b1, p1_a[p1 % 3], p1_b[p1 % 3], 1'b1, 1'b0, 4'(8 + p1));
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        repeat (4) tick();

        // 1.0 + 2.0 on port 0: result visible exactly one edge after accept.
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4'd3, 32'h40400000, 1'b1);
        @(negedge clock);
        check("lat_not_early", 32'(io_resp0_valid), 32'd0);
        @(negedge clock);
        check("lat_one_cycle", 32'(io_resp0_valid), 32'd1);
        tick();

        // 3.0 - 1.0 on port 1; port 0 stays quiet.
        issue(1, 32'h40400000, 32'h3F800000, 1'b1, 1'b0, 4'd5, 32'h40000000, 1'b1);
        repeat (3) begin
            @(negedge clock);
            check("resp0_quiet", 32'(io_resp0_valid), 32'd0);
        end
        tick();

        // Compare mode: unit output is passed through untouched.
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, 4'd7, 32'd1, 1'b1);
        repeat (3) tick();

        // Backpressure: slot 0 full, second op blocks, operands held, no ready.
        io_resp0_ready = 1'b0;
        issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 4'd1, 32'h40000000, 1'b1);
        issue(0, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 4'd2, 32'h40800000, 1'b1);
        set_req(0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 4'd15);
        set_req(1, 1'b1, 32'h40400000, 32'h3F800000, 1'b1, 1'b0, 4'd14);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("wait_req0_ready", 32'(io_req0_ready), 32'd0);
            check("wait_req1_ready", 32'(io_req1_ready), 32'd0);
            check("wait_fpu_a", io_fpu_a, 32'h40000000);
            check("wait_fpu_b", io_fpu_b, 32'h40000000);
            check("wait_old_y", io_resp0_bits_y, 32'h40000000);
            tick();
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        io_resp0_ready = 1'b1;
        @(negedge clock);
        tick();
        @(negedge clock);
        check("same_edge_valid", 32'(io_resp0_valid), 32'd1);
        check("same_edge_new_y", io_resp0_bits_y, 32'h40800000);
        tick();
        @(negedge clock);
        check("drained_valid", 32'(io_resp0_valid), 32'd0);
        tick();

        // Reset one cycle after accept discards the operation.
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4'd9, 32'h40400000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("post_rst_resp0", 32'(io_resp0_valid), 32'd0);
            check("post_rst_resp1", 32'(io_resp1_valid), 32'd0);
            check("post_rst_fpu_a", io_fpu_a, 32'd0);
            check("post_rst_y", io_resp0_bits_y, 32'd0);
        end
        tick();
        issue(0, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 4'd6, 32'h40800000, 1'b1);

        while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin
            tick();
            t++;
        end
        check("sb0_empty", 32'(q0.size()), 32'd0);
        check("sb1_empty", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fpu_add_arbiter.md
FPU_ADD_ARBITER -- requirements
Module: fpu_add_arbiter

Interface
REQ-001 SHALL have parameter: TAG_W, default 4, width of the requester tag carried with each operation.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: io_reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 SHALL have ports: io_reqN_ready  output  1  operation N accepted on this edge when valid.
REQ-006 SHALL have ports: io_reqN_bits_a, io_reqN_bits_b  input  32  IEEE-754 single operands.
REQ-007 SHALL have ports: io_reqN_bits_sub, io_reqN_bits_comp  input  1  subtract select; compare select.
REQ-008 SHALL have ports: io_reqN_bits_tag  input  TAG_W  requester-defined tag, returned unchanged.
REQ-009 SHALL have ports: io_fpu_a, io_fpu_b  output  32; io_fpu_sub, io_fpu_comp  output  1  drive the shared combinational FloatingPointAddSubComp.
REQ-010 SHALL have port: io_fpu_y  input  32  combinational result from the shared unit.
REQ-011 SHALL have ports: io_respN_valid  output  1; io_respN_ready  input  1; io_respN_bits_y  output  32; io_respN_bits_tag  output  TAG_W  per-requester result slot.

Function
REQ-012 SHALL hold one operand register (valid, src, a, b, sub, comp, tag) and one result slot per requester (valid, y, tag).
REQ-013 SHALL drive io_fpu_* from the operand register when valid, else all zero.
REQ-014 SHALL implement states IDLE (operand reg empty), EXEC (operand reg valid, first cycle), WAIT (operand reg valid, result slot of src full and not dequeued).
REQ-015 SHALL complete in EXEC/WAIT when slot[src] empty or io_resp[src]_ready high this cycle: write io_fpu_y and tag into slot[src] at the edge; a slot dequeue and write on the same edge leaves it valid with new data.
REQ-016 SHALL transition EXEC->WAIT when not completing, WAIT->WAIT while blocked, EXEC/WAIT->IDLE on completion with no accept, and IDLE/EXEC/WAIT->EXEC on accept.
REQ-017 SHALL accept a new request when state IDLE or completing this cycle (one operation per cycle throughput).
REQ-018 SHALL assert io_reqN_ready only for the granted port, and only when accepting is allowed; ready of the non-granted port SHALL be 0.
REQ-019 SHALL give latency one cycle: accepted on edge k, io_respN_valid high after edge k+1 when unblocked.
REQ-020 SHALL hold io_fpu_* stable throughout WAIT.
REQ-021 SHALL pass io_fpu_y unmodified in both add/sub and compare modes.
REQ-022 SHALL clear slot N valid on edge where io_respN_valid and io_respN_ready both high and no write to slot N occurs.

Reset
REQ-023 SHALL on reset: state IDLE, operand reg and both result slots invalid, io_reqN_ready 0, io_respN_valid 0, io_respN_bits_* 0, io_fpu_* 0, round-robin pointer = 1 (port 0 wins first).
REQ-024 SHALL discard any in-flight operation and unread results when reset asserts mid-operation; no response for it after reset.

Configuration
REQ-025 SHALL with FPU_ARB_RR_EN defined grant round-robin: with both valid, grant the port not last accepted; pointer updates only on accept.
REQ-026 SHALL without FPU_ARB_RR_EN grant fixed priority, port 0 over port 1; no pointer register.

Verification
REQ-027 SHALL cover: req0 a=0x3F800000, b=0x40000000, sub=0, tag=3 -> resp0 y=0x40400000, tag=3, one cycle after accept.
REQ-028 SHALL cover: req1 a=0x40400000, b=0x3F800000, sub=1 -> resp1 y=0x40000000; resp0_valid stays 0.
REQ-029 SHALL cover: both ports valid continuously for 6 cycles, resp ready high, FPU_ARB_RR_EN defined -> grants 0,1,0,1,0,1; undefined -> six grants to port 0, port 1 starved.
REQ-030 SHALL cover: resp0_ready low with slot0 full, second req0 accepted -> state WAIT, io_fpu_* held, both req_ready 0; raise resp0_ready -> old result dequeued, new written same edge.
REQ-031 SHALL cover: reset pulse one cycle after accept -> no resp valid afterwards; all outputs at reset values; next request completes normally.
